decoder_ifns_8di_seq: RTL and testbench

DECODER_IFNS_8DI_SEQ -- requirements
Module: decoder_ifns_8di_seq

---
 rtl/ifns_8di_pkg.sv | 29 ++
 rtl/ifns_weight_rom.sv | 27 ++
 rtl/decoder_ifns_8di_seq.sv | 110 +++++++++++
 tb/tb_decoder_ifns_8di_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ifns_8di_pkg.sv
// ifns_8di_pkg
// Shared definitions for the sequential IFNS 8-bit decoder:
//   - codeword / data / accumulator / index widths
//   - per-bit weight table W[k], k = 1..11 (entries 0 and 12..15 are zero)
//   - FSM state enumeration
package ifns_8di_pkg;

    localparam int CW_W   = 11;  // codeword width
    localparam int DATA_W = 8;   // decoded data width
    localparam int ACC_W  = 9;   // holds the largest sum, 287
    localparam int IDX_W  = 4;   // bit index 1..11

    localparam logic [IDX_W-1:0] IDX_TOP  = 4'd11;
    localparam logic [IDX_W-1:0] IDX_LAST = 4'd1;

    // Weight of codeword bit d[k] lives at entry k. The top weight is 144
    // rather than the next Fibonacci number, so sums run past 255.
    localparam logic [DATA_W-1:0] WEIGHT_TABLE [16] = '{
        8'd0,   8'd1,  8'd1,  8'd2,  8'd3,  8'd5,  8'd8,  8'd13,
        8'd21,  8'd34, 8'd55, 8'd144, 8'd0, 8'd0,  8'd0,  8'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ifns_weight_rom.sv
// ifns_weight_rom
// Combinational lookup of the weight for one codeword bit position.
// Ports:
//   idx    [3:0] in  : bit position k (1..11 are meaningful)
//   weight [7:0] out : W[k]; zero for idx 0 and 12..15
module ifns_weight_rom
    import ifns_8di_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] weight
);

    // One-hot select across the table so every entry is an explicit mux leg.
    logic [DATA_W-1:0] leg [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_leg
        assign leg[gi] = (idx == IDX_W'(gi)) ? WEIGHT_TABLE[gi] : '0;
    end

    always_comb begin
        weight = '0;
        for (int i = 0; i < 16; i++) begin
            weight = weight | leg[i];
        end
    end

endmodule

// File: rtl/decoder_ifns_8di_seq.sv
// decoder_ifns_8di_seq
// Bit-serial IFNS decoder: accepts an 11-bit codeword, walks d[11]..d[1]
// one bit per clock, accumulating d[k]*W[k] into a 9-bit sum, then presents
// the low 8 bits plus an overflow flag until the consumer takes them.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : codeword handshake, in_cw[k-1] = d[k]
//   out_valid / out_ready: result handshake
//   out_data [7:0]       : sum[7:0], zero while out_valid = 0
//   out_err              : sum[8] (codeword decodes above 255)
module decoder_ifns_8di_seq
    import ifns_8di_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    state_t              state_reg;
    logic [CW_W-1:0]     cw_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [DATA_W-1:0]   weight;

    logic                in_ready_reg;
    logic                out_valid_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic                out_err_reg;

    ifns_weight_rom u_weight_rom (
        .idx    (idx_reg),
        .weight (weight)
    );

    // The captured codeword is shifted left each ACC cycle, so its MSB is
    // always the bit d[idx_reg] being processed.
    always_comb begin
        acc_next = acc_reg;
        if (cw_reg[CW_W-1]) begin
            acc_next = acc_reg + ACC_W'(weight);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cw_reg        <= '0;
            acc_reg       <= '0;
            idx_reg       <= IDX_TOP;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        cw_reg       <= in_cw;
                        acc_reg      <= '0;
                        idx_reg      <= IDX_TOP;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_reg <= acc_next;
                    cw_reg  <= cw_reg << 1;
                    idx_reg <= idx_reg - 4'd1;
                    if (idx_reg == IDX_LAST) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= acc_next[DATA_W-1:0];
                        out_err_reg   <= acc_next[ACC_W-1];
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // in_ready goes high together with the return to IDLE,
                    // so no codeword is taken on the consuming edge.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= '0;
                        out_err_reg   <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                    out_err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_err   = out_err_reg;

endmodule

// File: tb/tb_decoder_ifns_8di_seq.sv
// tb_decoder_ifns_8di_seq
// Directed vector table plus hand-written sequences for backpressure,
// mid-ACC reset, throughput and a full 0..255 encode/decode sweep.
module tb_decoder_ifns_8di_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_cw;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_accept = 0;

    decoder_ifns_8di_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] cw;
        logic [7:0]  data;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Greedy encoder over the same weights; always terminates at 0 for v<=287.
    function automatic logic [10:0] encode(input int v);
        int w [11] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 144};
        logic [10:0] cw = '0;
        int rem = v;
        for (int k = 10; k >= 0; k--) begin
            if (rem >= w[k]) begin
                cw[k] = 1'b1;
                rem -= w[k];
            end
        end
        return cw;
    endfunction

    // Send one codeword, check latency and result, hold out_ready low for
    // 'hold' cycles checking stability, then consume. Called at a negedge.
    task automatic run_one(input logic [10:0] cw, input logic [7:0] ed,
                           input logic ee, input int hold, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({tag, " in_ready_timeout"}, 0, 1);
        in_valid = 1'b1;
        in_cw    = cw;
        @(posedge clk);
        last_accept = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_cw    = ~cw;  // must not affect the result
        n = 1;
        while (!out_valid && n < 50) begin
            if (out_data !== 8'h00 || out_err !== 1'b0) chk({tag, " idle_data_zero"}, out_data, 0);
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 12);
        chk({tag, " data"}, out_data, ed);
        chk({tag, " err"}, out_err, ee);
        $display("cw=%03h data=%02h err=%0d lat=%0d [%s]", cw, out_data, out_err, n, tag);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, out_valid, 1);
            chk({tag, " hold_data"}, out_data, ed);
            chk({tag, " hold_err"}, out_err, ee);
            chk({tag, " hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " post_valid"}, out_valid, 0);
        chk({tag, " post_in_ready"}, in_ready, 1);
        chk({tag, " post_data"}, {out_err, out_data}, 0);
    endtask

    vec_t vecs [12];

    initial begin
        int t0;
        vecs[0]  = '{11'h000, 8'h00, 1'b0};
        vecs[1]  = '{11'h781, 8'hFF, 1'b0};
        vecs[2]  = '{11'h400, 8'h90, 1'b0};
        vecs[3]  = '{11'h7FF, 8'h1F, 1'b1};
        vecs[4]  = '{11'h001, 8'h01, 1'b0};
        vecs[5]  = '{11'h002, 8'h01, 1'b0};
        vecs[6]  = '{11'h003, 8'h02, 1'b0};
        vecs[7]  = '{11'h200, 8'h37, 1'b0};
        vecs[8]  = '{11'h555, 8'hC7, 1'b0};
        vecs[9]  = '{11'h2AA, 8'h58, 1'b0};
        vecs[10] = '{11'h782, 8'hFF, 1'b0};
        vecs[11] = '{11'h783, 8'h00, 1'b1};

        // Reset with in_valid high: reset must win.
        rst = 1'b1; in_valid = 1'b1; in_cw = 11'h7FF; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_err", out_err, 0);

        for (int i = 0; i < 12; i++) begin
            run_one(vecs[i].cw, vecs[i].data, vecs[i].err, (i == 1) ? 5 : 0, "vec");
        end

        // Throughput: back-to-back with immediate consumption.
        run_one(11'h781, 8'hFF, 1'b0, 0, "tput_a");
        t0 = last_accept;
        run_one(11'h400, 8'h90, 1'b0, 0, "tput_b");
        chk("throughput", last_accept - t0, 13);

        // Reset in the 6th ACC cycle.
        in_valid = 1'b1; in_cw = 11'h7FF;
        @(negedge clk);          // accepted; now in ACC cycle 1
        in_valid = 1'b0;
        repeat (5) @(negedge clk);  // ACC cycle 6
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midacc in_ready", in_ready, 1);
        chk("midacc out_valid", out_valid, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) chk("midacc no_output", out_valid, 0);
        end
        $display("mid-ACC reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);
        run_one(11'h781, 8'hFF, 1'b0, 0, "after_rst");

        // Full sweep over every encoder output with random backpressure.
        for (int v = 0; v < 256; v++) begin
            run_one(encode(v), v[7:0], 1'b0, int'($urandom_range(0, 2)), "sweep");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
